// File: rtl/jtag_scan_pkg.sv
// Shared definitions for the host-side JTAG debug scan master.
// Op encoding, TAP walk states and sync length.
package jtag_scan_pkg;

    localparam logic [1:0] OP_RESET = 2'd0;
    localparam logic [1:0] OP_IR    = 2'd1;
    localparam logic [1:0] OP_DR    = 2'd2;

    localparam int SYNC_TMS_ONES = 5;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SYNC,
        ST_SEL_DR,
        ST_SEL_IR,
        ST_CAPTURE,
        ST_SHIFT,
        ST_EXIT1,
        ST_UPDATE,
        ST_RESP
    } walk_e;

endpackage

// File: rtl/jtag_tck_gen.sv
// TCK divider: toggles tck every CLK_DIV clk while enabled.
// rise_tick/fall_tick flag the clk edge on which tck goes high/low.
module jtag_tck_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    output logic tck,
    output logic rise_tick,
    output logic fall_tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt;
    logic          tick;

    assign tick      = en && (cnt == CW'(CLK_DIV - 1));
    assign rise_tick = tick && !tck;
    assign fall_tick = tick && tck;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
            tck <= 1'b0;
        end else if (!en) begin
            cnt <= '0;
            tck <= 1'b0;
        end else if (tick) begin
            cnt <= '0;
            tck <= ~tck;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/jtag_debug_scan_master.sv
// Host-side JTAG scan engine: walks the TAP for IR/DR scans
// and returns the captured tdo bits.
module jtag_debug_scan_master
    import jtag_scan_pkg::*;
#(
    parameter int DR_MAX  = 38,
    parameter int CLK_DIV = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [5:0]        cmd_len,
    input  logic [DR_MAX-1:0] cmd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DR_MAX-1:0] rsp_data,
    output logic              rsp_err,
    output logic              busy,
    output logic              tck,
    output logic              tms,
    output logic              tdi,
    input  logic              tdo
);

    localparam logic [6:0] MAX_LEN = 7'(DR_MAX);

    walk_e             state;
    logic [1:0]        op_q;
    logic [5:0]        len_q;
    logic [5:0]        cnt;
    logic [DR_MAX-1:0] sreg;
    logic [DR_MAX-1:0] sh_next;
    logic [DR_MAX-1:0] mask;
    logic              tap_synced;
    logic              en;
    logic              rise_tick;
    logic              fall_tick;
    logic              illegal;

    assign en      = (state != ST_IDLE) && (state != ST_RESP);
    assign illegal = (cmd_len == 6'd0) || ({1'b0, cmd_len} > MAX_LEN) ||
                     (cmd_op == 2'd3);
    assign mask    = ~({DR_MAX{1'b1}} << cmd_len);

    jtag_tck_gen #(.CLK_DIV(CLK_DIV)) u_tck_gen (
        .clk      (clk),
        .reset_n  (reset_n),
        .en       (en),
        .tck      (tck),
        .rise_tick(rise_tick),
        .fall_tick(fall_tick)
    );

    // Captured tdo lands at bit len-1 so the result ends right-aligned.
    always_comb begin
        sh_next = sreg >> 1;
        sh_next[len_q - 6'd1] = tdo;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            cmd_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_err    <= 1'b0;
            rsp_data   <= '0;
            busy       <= 1'b0;
            tms        <= 1'b1;
            tdi        <= 1'b0;
            tap_synced <= 1'b0;
            op_q       <= OP_RESET;
            len_q      <= '0;
            cnt        <= '0;
            sreg       <= '0;
        end else begin
            if (rise_tick && state == ST_SHIFT)
                sreg <= sh_next;
            unique case (state)
                ST_IDLE: if (cmd_valid) begin
                    cmd_ready <= 1'b0;
                    busy      <= 1'b1;
                    op_q      <= cmd_op;
                    len_q     <= cmd_len;
                    cnt       <= '0;
                    if (illegal) begin
                        state     <= ST_RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_data  <= '0;
                    end else begin
                        sreg  <= (cmd_op == OP_RESET) ? '0 : (cmd_data & mask);
                        tms   <= 1'b1;
                        state <= (cmd_op == OP_RESET || !tap_synced) ?
                                 ST_SYNC : ST_SEL_DR;
                    end
                end
                ST_SYNC: if (fall_tick) begin
                    if (cnt == 6'(SYNC_TMS_ONES)) begin
                        tap_synced <= 1'b1;
                        cnt        <= '0;
                        if (op_q == OP_RESET) begin
                            state     <= ST_RESP;
                            rsp_valid <= 1'b1;
                            rsp_data  <= '0;
                        end else begin
                            state <= ST_SEL_DR;
                            tms   <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 6'd1;
                        tms <= (cnt < 6'(SYNC_TMS_ONES - 1));
                    end
                end
                ST_SEL_DR: if (fall_tick) begin
                    if (op_q == OP_IR) begin
                        state <= ST_SEL_IR;
                        tms   <= 1'b1;
                    end else begin
                        state <= ST_CAPTURE;
                        tms   <= 1'b0;
                        cnt   <= '0;
                    end
                end
                ST_SEL_IR: if (fall_tick) begin
                    state <= ST_CAPTURE;
                    tms   <= 1'b0;
                    cnt   <= '0;
                end
                // Two tms=0 tcks: into Capture, then into Shift.
                ST_CAPTURE: if (fall_tick) begin
                    if (cnt == 6'd0) begin
                        cnt <= 6'd1;
                    end else begin
                        state <= ST_SHIFT;
                        cnt   <= '0;
                        tms   <= (len_q == 6'd1);
                        tdi   <= sreg[0];
                    end
                end
                ST_SHIFT: if (fall_tick) begin
                    if (cnt == len_q - 6'd1) begin
                        state <= ST_EXIT1;
                        tms   <= 1'b1;
                        tdi   <= 1'b0;
                    end else begin
                        cnt <= cnt + 6'd1;
                        tms <= (cnt + 6'd2 == len_q);
                        tdi <= sreg[0];
                    end
                end
                ST_EXIT1: if (fall_tick) begin
                    state <= ST_UPDATE;
                    tms   <= 1'b0;
                end
                ST_UPDATE: if (fall_tick) begin
                    state     <= ST_RESP;
                    rsp_valid <= 1'b1;
                    rsp_data  <= sreg;
                end
                ST_RESP: if (rsp_ready) begin
                    state     <= ST_IDLE;
                    rsp_valid <= 1'b0;
                    rsp_err   <= 1'b0;
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jtag_debug_scan_master.sv
// Testbench for jtag_debug_scan_master: directed and random scans
// checked against a tms/tdi/tdo sequence model.
module tb_jtag_debug_scan_master;

    localparam int DR_MAX  = 38;
    localparam int CLK_DIV = 2;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [1:0]        cmd_op = '0;
    logic [5:0]        cmd_len = '0;
    logic [DR_MAX-1:0] cmd_data = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [DR_MAX-1:0] rsp_data;
    logic              rsp_err;
    logic              busy;
    logic              tck, tms, tdi, tdo;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] got_tms = '0;
    logic [63:0] got_tdi = '0;
    logic [63:0] tdo_plan = '0;
    int          nrise = 0;
    logic        loop = 1'b0;
    logic        tdo_r = 1'b0;
    bit          synced_m = 1'b0;

    always #5 clk = ~clk;

    jtag_debug_scan_master #(.DR_MAX(DR_MAX), .CLK_DIV(CLK_DIV)) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_len(cmd_len), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy),
        .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo)
    );

    assign tdo = loop ? tdi : tdo_r;

    always @(posedge tck) begin
        if (nrise < 64) begin
            got_tms[nrise] = tms;
            got_tdi[nrise] = tdi;
        end
        nrise++;
    end

    always @(negedge tck)
        tdo_r = (nrise < 64) ? tdo_plan[nrise] : 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Builds the expected tck-by-tck walk straight from the TAP rules.
    task automatic model(input logic [1:0] op, input int len,
                         input logic [63:0] data, input logic [63:0] tgt,
                         output logic [63:0] etms, output logic [63:0] etdi,
                         output logic [63:0] plan, output int ntck);
        bit q[$];
        int s;
        if (!synced_m || op == 2'd0)
            for (int i = 0; i < 6; i++) q.push_back(i < 5);
        if (op == 2'd1) begin
            q.push_back(1); q.push_back(1); q.push_back(0); q.push_back(0);
        end
        if (op == 2'd2) begin
            q.push_back(1); q.push_back(0); q.push_back(0);
        end
        s = q.size();
        if (op != 2'd0) begin
            for (int i = 0; i < len; i++) q.push_back(i == len - 1);
            q.push_back(1);
            q.push_back(0);
        end
        etms = '0; etdi = '0; plan = '0;
        foreach (q[i]) etms[i] = q[i];
        if (op != 2'd0)
            for (int i = 0; i < len; i++) begin
                etdi[s+i] = data[i];
                plan[s+i] = tgt[i];
            end
        ntck = q.size();
    endtask

    task automatic send(input logic [1:0] op, input int len,
                        input logic [63:0] data);
        int n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("cmd_ready_wait", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_len   = 6'(len);
        cmd_data  = data[DR_MAX-1:0];
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic prep(input logic [1:0] op, input int len,
                        input logic [63:0] data, input logic [63:0] tgt,
                        input bit lp, output logic [63:0] etms,
                        output logic [63:0] etdi, output int ntck);
        logic [63:0] plan;
        model(op, len, data, tgt, etms, etdi, plan, ntck);
        loop     = lp;
        tdo_plan = plan;
        nrise    = 0;
        got_tms  = '0;
        got_tdi  = '0;
        tdo_r    = plan[0];
    endtask

    task automatic run_cmd(input string tag, input logic [1:0] op,
                           input int len, input logic [63:0] data,
                           input logic [63:0] tgt, input bit lp,
                           input bit hold);
        logic [63:0] etms, etdi, exp_rsp, m;
        int ntck, cyc;
        bit legal;
        legal = (len >= 1) && (len <= DR_MAX) && (op != 2'd3);
        m = (64'd1 << len) - 64'd1;
        if (legal) begin
            prep(op, len, data, tgt, lp, etms, etdi, ntck);
        end else begin
            prep(2'd0, 0, 64'd0, 64'd0, lp, etms, etdi, ntck);
            etms = '0;
            ntck = 0;
        end
        exp_rsp = (legal && op != 2'd0) ? ((lp ? data : tgt) & m) : 64'd0;
        send(op, len, data);
        cyc = 0;
        while (!rsp_valid && cyc < 3000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk({tag, "_rsp_valid"}, rsp_valid, 1);
        chk({tag, "_latency"}, cyc, 4 * ntck);
        chk({tag, "_ntck"}, nrise, ntck);
        chk({tag, "_tms"}, got_tms, etms);
        chk({tag, "_tdi"}, got_tdi, etdi);
        chk({tag, "_rsp_data"}, rsp_data, exp_rsp);
        chk({tag, "_rsp_err"}, rsp_err, !legal);
        chk({tag, "_busy"}, busy, 1);
        chk({tag, "_cmd_ready_low"}, cmd_ready, 0);
        chk({tag, "_tck_idle"}, tck, 0);
        if (hold) begin
            repeat (10) @(posedge clk);
            #1;
            chk({tag, "_hold_valid"}, rsp_valid, 1);
            chk({tag, "_hold_ready"}, cmd_ready, 0);
            chk({tag, "_hold_data"}, rsp_data, exp_rsp);
            chk({tag, "_hold_ntck"}, nrise, ntck);
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        chk({tag, "_hs_valid"}, rsp_valid, 0);
        chk({tag, "_hs_busy"}, busy, 0);
        chk({tag, "_hs_ready"}, cmd_ready, 1);
        if (legal) synced_m = 1'b1;
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("rst_tck", tck, 0);
        chk("rst_tms", tms, 1);
        chk("rst_tdi", tdi, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        synced_m = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        logic [63:0] d, t, etms, etdi;
        logic [1:0]  op;
        int          len, ntck, n;

        repeat (2) @(negedge clk);
        chk("reset_cmd_ready", cmd_ready, 1);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_rsp_err", rsp_err, 0);
        chk("reset_rsp_data", rsp_data, 0);
        chk("reset_busy", busy, 0);
        chk("reset_tck", tck, 0);
        chk("reset_tms", tms, 1);
        chk("reset_tdi", tdi, 0);
        reset_n = 1'b1;

        run_cmd("tap_reset", 2'd0, 1, 64'd0, 64'd0, 1'b0, 1'b0);
        run_cmd("ir2", 2'd1, 2, 64'd2, 64'd0, 1'b1, 1'b0);
        run_cmd("dr38", 2'd2, 38, 64'h2AAAAAAAAA, 64'h1555555555,
                1'b0, 1'b0);

        reset_pulse();
        run_cmd("dr1_unsynced", 2'd2, 1, 64'd1, 64'd1, 1'b0, 1'b0);

        run_cmd("err_len0", 2'd2, 0, 64'h5, 64'h0, 1'b0, 1'b0);
        run_cmd("err_len39", 2'd1, 39, 64'h5, 64'h0, 1'b0, 1'b0);
        run_cmd("err_op3", 2'd3, 5, 64'h5, 64'h0, 1'b0, 1'b0);

        for (int i = 0; i < 8; i++) begin
            op  = ($urandom_range(0, 1) == 0) ? 2'd1 : 2'd2;
            len = $urandom_range(1, DR_MAX);
            d   = {$urandom, $urandom};
            t   = {$urandom, $urandom};
            run_cmd("rand", op, len, d, t, 1'b0, 1'b0);
        end

        prep(2'd2, 38, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0,
             etms, etdi, ntck);
        send(2'd2, 38, {$urandom, $urandom});
        n = 0;
        while (nrise < 20 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        chk("midshift_reached", nrise >= 20, 1);
        reset_pulse();

        d = {$urandom, $urandom};
        t = {$urandom, $urandom};
        run_cmd("after_midreset", 2'd2, $urandom_range(1, DR_MAX), d, t,
                1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
